// File: rtl/neureka_package.sv
// Shared constants, control/flag structs and small helpers for the NEUREKA
// weight ping-pong buffer.
// Build option: NEUREKA_WBUF_PERF_EN adds stall/starve performance counters.
package neureka_package;

    localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 288;
    localparam int unsigned NEUREKA_WBUF_DEPTH        = 8;

    // Control fields are carried at a fixed 16-bit width so the structs do
    // not depend on per-instance parameters; the top narrows them on latch.
    typedef struct packed {
        logic        start;
        logic [15:0] block_len;
        logic [15:0] rpt;
    } ctrl_wbuf_t;

    typedef struct packed {
        logic [1:0] bank_full;
        logic       idle;
    } flags_wbuf_t;

    // Block length of 0 means 1; anything above the bank depth saturates.
    function automatic logic [15:0] wbuf_sat_len(input logic [15:0] len,
                                                 input logic [15:0] depth);
        if (len == 16'd0)
            return 16'd1;
        else if (len > depth)
            return depth;
        else
            return len;
    endfunction

    // Index of the final replay: a repeat count of 0 behaves as 1.
    function automatic logic [15:0] wbuf_rpt_last(input logic [15:0] rpt);
        return (rpt == 16'd0) ? 16'd0 : rpt - 16'd1;
    endfunction

endpackage

// File: rtl/neureka_wbuf_bank.sv
// One weight bank: registered write port, combinational read port.
// No storage reset; the top masks read data whenever its output is not valid.
module neureka_wbuf_bank #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic [DW/8-1:0]   wstrb_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DW-1:0]     rdata_o,
    output logic [DW/8-1:0]   rstrb_o
);

    logic [DW-1:0]   r_data [DEPTH];
    logic [DW/8-1:0] r_strb [DEPTH];

    // Capture one word and its strobe on a write enable.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_data[waddr_i] <= wdata_i;
            r_strb[waddr_i] <= wstrb_i;
        end
    end

    assign rdata_o = r_data[raddr_i];
    assign rstrb_o = r_strb[raddr_i];

endmodule

// File: rtl/neureka_weight_pingpong.sv
// Double-buffered weight replay buffer between streamer and engine.
// One bank fills from push while the other replays its block repeat times.
// Build option: NEUREKA_WBUF_PERF_EN adds perf_stall_o / perf_starve_o.
//
// Handshake: both streams transfer a word on a rising clock edge where
// valid and ready are both 1; the source holds valid and data stable until
// that transfer. start_i, rst_i and clear_i abort both streams (ready and
// valid forced low) in the cycle they are asserted.
module neureka_weight_pingpong
    import neureka_package::*;
#(
    parameter int unsigned DW    = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int unsigned DEPTH = NEUREKA_WBUF_DEPTH,
    parameter int unsigned RPT_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic [$clog2(DEPTH+1)-1:0] block_len_i,
    input  logic [RPT_W-1:0]           repeat_i,
    input  logic                       push_valid_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic [DW/8-1:0]            push_strb_i,
    output logic                       push_ready_o,
    output logic                       pop_valid_o,
    output logic [DW-1:0]              pop_data_o,
    output logic [DW/8-1:0]            pop_strb_o,
    input  logic                       pop_ready_i,
    output logic [1:0]                 bank_full_o,
    output logic                       idle_o,
    output logic                       drain_state_o
`ifdef NEUREKA_WBUF_PERF_EN
    ,
    output logic [31:0]                perf_stall_o,
    output logic [31:0]                perf_starve_o
`endif
);

    localparam int unsigned LEN_W = $clog2(DEPTH+1);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SW    = DW/8;

    localparam logic [0:0] D_IDLE = 1'b0;
    localparam logic [0:0] D_RUN  = 1'b1;

    ctrl_wbuf_t  w_ctrl;
    flags_wbuf_t w_flags;

    logic [0:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [RPT_W-1:0] r_rpt_last;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic             r_fill_sel;
    logic             r_drain_sel;
    logic [1:0]       r_full;
    logic             r_idle;

    logic             w_kill;
    logic             w_push_hs;
    logic             w_pop_hs;
    logic             w_wr_last;
    logic             w_rd_last;
    logic             w_rpt_last;
    logic             w_fill_done;
    logic             w_drain_done;
    logic [1:0]       w_full_nxt;
    logic             w_idle_nxt;
    logic [DW-1:0]    w_b0_data;
    logic [DW-1:0]    w_b1_data;
    logic [SW-1:0]    w_b0_strb;
    logic [SW-1:0]    w_b1_strb;

    assign w_ctrl = '{start: start_i, block_len: 16'(block_len_i), rpt: 16'(repeat_i)};

    assign w_kill       = w_ctrl.start | rst_i | clear_i;
    assign push_ready_o = enable_i & ~r_full[r_fill_sel] & ~w_kill;
    assign pop_valid_o  = enable_i & (r_state == D_RUN) & ~w_kill;
    assign w_push_hs    = push_valid_i & push_ready_o;
    assign w_pop_hs     = pop_valid_o & pop_ready_i;

    assign w_wr_last    = (LEN_W'(r_wr_idx) == r_len - 1'b1);
    assign w_rd_last    = (LEN_W'(r_rd_idx) == r_len - 1'b1);
    assign w_rpt_last   = (r_rpt_cnt == r_rpt_last);
    assign w_fill_done  = w_push_hs & w_wr_last;
    assign w_drain_done = w_pop_hs & w_rd_last & w_rpt_last;

    // Idle is registered from next-cycle occupancy so it rises right after
    // the last bank frees; in D_RUN the drained bank is full until done.
    assign w_full_nxt = (r_full | (w_fill_done ? (2'b01 << r_fill_sel) : 2'b00))
                      & ~(w_drain_done ? (2'b01 << r_drain_sel) : 2'b00);
    assign w_idle_nxt = (w_full_nxt == 2'b00) & ((r_state == D_IDLE) | w_drain_done);

    neureka_wbuf_bank #(.DW(DW), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank0 (
        .clk_i   (clk_i),
        .we_i    (w_push_hs & ~r_fill_sel),
        .waddr_i (r_wr_idx),
        .wdata_i (push_data_i),
        .wstrb_i (push_strb_i),
        .raddr_i (r_rd_idx),
        .rdata_o (w_b0_data),
        .rstrb_o (w_b0_strb)
    );

    neureka_wbuf_bank #(.DW(DW), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank1 (
        .clk_i   (clk_i),
        .we_i    (w_push_hs & r_fill_sel),
        .waddr_i (r_wr_idx),
        .wdata_i (push_data_i),
        .wstrb_i (push_strb_i),
        .raddr_i (r_rd_idx),
        .rdata_o (w_b1_data),
        .rstrb_o (w_b1_strb)
    );

    assign pop_data_o = pop_valid_o ? (r_drain_sel ? w_b1_data : w_b0_data) : '0;
    assign pop_strb_o = pop_valid_o ? (r_drain_sel ? w_b1_strb : w_b0_strb) : '0;

    assign w_flags       = '{bank_full: r_full, idle: r_idle};
    assign bank_full_o   = w_flags.bank_full;
    assign idle_o        = w_flags.idle;
    assign drain_state_o = r_state;

    // Fill pointer, bank occupancy and drain FSM; start restarts everything.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state     <= D_IDLE;
            r_len       <= LEN_W'(1);
            r_rpt_last  <= '0;
            r_rpt_cnt   <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_fill_sel  <= 1'b0;
            r_drain_sel <= 1'b0;
            r_full      <= 2'b00;
            r_idle      <= 1'b1;
        end else if (w_ctrl.start) begin
            r_state     <= D_IDLE;
            r_len       <= LEN_W'(wbuf_sat_len(w_ctrl.block_len, 16'(DEPTH)));
            r_rpt_last  <= RPT_W'(wbuf_rpt_last(w_ctrl.rpt));
            r_rpt_cnt   <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_fill_sel  <= 1'b0;
            r_drain_sel <= 1'b0;
            r_full      <= 2'b00;
            r_idle      <= 1'b1;
        end else if (enable_i) begin
            if (w_push_hs) begin
                if (w_wr_last) begin
                    r_full[r_fill_sel] <= 1'b1;
                    r_wr_idx           <= '0;
                    r_fill_sel         <= ~r_fill_sel;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end
            case (r_state)
                D_IDLE: begin
                    // A block completing into the bank we drain next starts
                    // replay immediately, saving a cycle of fill latency.
                    if (r_full[r_drain_sel] || (w_fill_done && (r_fill_sel == r_drain_sel)))
                        r_state <= D_RUN;
                end
                D_RUN: begin
                    if (w_pop_hs) begin
                        if (w_rd_last) begin
                            r_rd_idx <= '0;
                            if (w_rpt_last) begin
                                r_full[r_drain_sel] <= 1'b0;
                                r_rpt_cnt           <= '0;
                                r_drain_sel         <= ~r_drain_sel;
                                r_state             <= D_IDLE;
                            end else begin
                                r_rpt_cnt <= r_rpt_cnt + 1'b1;
                            end
                        end else begin
                            r_rd_idx <= r_rd_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= D_IDLE;
            endcase
            r_idle <= w_idle_nxt;
        end
    end

`ifdef NEUREKA_WBUF_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_starve;

    // Saturating counters of engine back-pressure and replay starvation.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i || w_ctrl.start) begin
            r_perf_stall  <= '0;
            r_perf_starve <= '0;
        end else if (enable_i) begin
            if ((r_state == D_RUN) && !pop_ready_i && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
            if ((r_state == D_IDLE) && ((r_full != 2'b00) || push_valid_i) && (r_perf_starve != '1))
                r_perf_starve <= r_perf_starve + 32'd1;
        end
    end

    assign perf_stall_o  = r_perf_stall;
    assign perf_starve_o = r_perf_starve;
`endif

endmodule

// File: tb/tb_neureka_weight_pingpong.sv
// Self-checking bench for neureka_weight_pingpong.
// Reference model: every accepted word is appended to the current block;
// once the block holds len words, the block repeated rpt times is appended
// to the expected pop queue. Define NEUREKA_WBUF_PERF_EN to also check the
// performance counters.
module tb_neureka_weight_pingpong;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 8;
  localparam int RPT_W = 8;
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int W     = DW + SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i, enable_i, clear_i, start_i;
  logic [LEN_W-1:0] block_len_i;
  logic [RPT_W-1:0] repeat_i;
  logic             push_valid, push_ready;
  logic [DW-1:0]    push_data;
  logic [SW-1:0]    push_strb;
  logic             pop_valid, pop_ready;
  logic [DW-1:0]    pop_data;
  logic [SW-1:0]    pop_strb;
  logic [1:0]       bank_full;
  logic             idle;
  logic             drain_state;
`ifdef NEUREKA_WBUF_PERF_EN
  logic [31:0]      perf_stall, perf_starve;
`endif

  neureka_weight_pingpong #(.DW(DW), .DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .block_len_i   (block_len_i),
    .repeat_i      (repeat_i),
    .push_valid_i  (push_valid),
    .push_data_i   (push_data),
    .push_strb_i   (push_strb),
    .push_ready_o  (push_ready),
    .pop_valid_o   (pop_valid),
    .pop_data_o    (pop_data),
    .pop_strb_o    (pop_strb),
    .pop_ready_i   (pop_ready),
    .bank_full_o   (bank_full),
    .idle_o        (idle),
    .drain_state_o (drain_state)
`ifdef NEUREKA_WBUF_PERF_EN
    ,
    .perf_stall_o  (perf_stall),
    .perf_starve_o (perf_starve)
`endif
  );

  // ---------------- bench state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_pop = 0;
  int n_acc = 0;
  int first_pop = -1;
  int last_pop = -1;
  int m_len = 1;
  int m_rpt = 1;
  int pop_mode = 1;  // 0: ready low, 1: ready high, 2: random

  logic [W-1:0] exp_q[$];
  logic [W-1:0] push_q[$];
  logic [W-1:0] blk[$];
  int           acc_cyc[$];

  logic         s_valid, s_ready, s_idle;
  logic [1:0]   s_full;
  logic [W-1:0] s_word;
  logic [W-1:0] held;
  bit           held_v = 0;

  // ---------------- scoreboard / model ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_cfg(input int len, input int rpt);
    m_len = (len == 0) ? 1 : ((len > DEPTH) ? DEPTH : len);
    m_rpt = (rpt == 0) ? 1 : rpt;
  endtask

  task automatic model_accept(input logic [W-1:0] w);
    blk.push_back(w);
    if (blk.size() == m_len) begin
      for (int r = 0; r < m_rpt; r++)
        for (int i = 0; i < m_len; i++)
          exp_q.push_back(blk[i]);
      blk.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    push_valid = (push_q.size() != 0);
    if (push_valid) {push_strb, push_data} = push_q[0];
    case (pop_mode)
      0:       pop_ready = 1'b0;
      1:       pop_ready = 1'b1;
      default: pop_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic add_words(input int n, input bit rand_strb);
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w[DW-1:0] = $urandom;
      w[W-1:DW] = rand_strb ? SW'($urandom) : {SW{1'b1}};
      push_q.push_back(w);
    end
  endtask

  // One clock: sample at negedge, account handshakes, re-drive after posedge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    s_valid = pop_valid;
    s_ready = push_ready;
    s_idle  = idle;
    s_full  = bank_full;
    s_word  = {pop_strb, pop_data};
    if (held_v) begin
      check("hold_valid", 64'(pop_valid), 64'd1);
      check("hold_word", 64'(s_word), 64'(held));
    end
    if (pop_valid && pop_ready) begin
      n_pop++;
      last_pop = cyc;
      if (first_pop < 0) first_pop = cyc;
      if (exp_q.size() == 0) check("pop_extra", 64'(exp_q.size()), 64'd1);
      else check("pop_word", 64'(s_word), 64'(exp_q.pop_front()));
    end
    held_v = pop_valid && !pop_ready;
    held   = s_word;
    if (push_valid && push_ready) begin
      n_acc++;
      acc_cyc.push_back(cyc);
      model_accept(push_q.pop_front());
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_done(input int budget);
    int k = 0;
    while ((push_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    check("drain_timeout", 64'(push_q.size() + exp_q.size()), 64'd0);
  endtask

  task automatic do_start(input int len, input int rpt);
    start_i     = 1'b1;
    block_len_i = LEN_W'(len);
    repeat_i    = RPT_W'(rpt);
    push_valid  = 1'b1;
    push_data   = $urandom;
    push_strb   = '1;
    pop_ready   = 1'b0;
    @(negedge clk);
    cyc++;
    check("start_push_ready", 64'(push_ready), 64'd0);
    check("start_pop_valid", 64'(pop_valid), 64'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    set_cfg(len, rpt);
    exp_q.delete();
    blk.delete();
    acc_cyc.delete();
    held_v    = 0;
    first_pop = -1;
    drive();
  endtask

  task automatic do_reset(input bit use_clear);
    if (use_clear) clear_i = 1'b1;
    else rst_i = 1'b1;
    @(negedge clk);
    cyc++;
    check(use_clear ? "clear_push_ready" : "rst_push_ready", 64'(push_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_i   = 1'b0;
    clear_i = 1'b0;
    push_q.delete();
    exp_q.delete();
    blk.delete();
    held_v = 0;
    set_cfg(1, 1);
    drive();
    cycle();
    check("post_rst_valid", 64'(s_valid), 64'd0);
    check("post_rst_word", 64'(s_word), 64'd0);
    check("post_rst_full", 64'(s_full), 64'd0);
    check("post_rst_idle", 64'(s_idle), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n0;
    int k;
    rst_i       = 1'b1;
    enable_i    = 1'b1;
    clear_i     = 1'b0;
    start_i     = 1'b0;
    block_len_i = LEN_W'(1);
    repeat_i    = RPT_W'(1);
    push_valid  = 1'b0;
    push_data   = '0;
    push_strb   = '0;
    pop_ready   = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_ready", 64'(push_ready), 64'd0);
    check("rst_valid", 64'(pop_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    pop_mode = 1;
    drive();
    cycle();
    check("reset_valid", 64'(s_valid), 64'd0);
    check("reset_word", 64'(s_word), 64'd0);
    check("reset_full", 64'(s_full), 64'd0);
    check("reset_idle", 64'(s_idle), 64'd1);
    check("reset_ready_enabled", 64'(s_ready), 64'd1);

    // len=4 repeat=3, two back-to-back blocks, ready always high
    do_start(4, 3);
    pop_mode = 1;
    add_words(8, 0);
    drive();
    run_until_done(200);
    check("t1_span", 64'(last_pop - first_pop + 1), 64'd25);
    check("t1_latency", 64'(first_pop), 64'(acc_cyc[3] + 1));
    check("t1_idle_busy", 64'(s_idle), 64'd0);
    cycle();
    check("t1_idle", 64'(s_idle), 64'd1);

    // len=2 repeat=0 with engine stalled: both banks fill, then drain
    do_start(2, 0);
    pop_mode = 0;
    add_words(6, 0);
    n0 = n_acc;
    drive();
    repeat (12) cycle();
    check("t2_accepted", 64'(n_acc - n0), 64'd4);
    check("t2_bank_full", 64'(s_full), 64'd3);
    check("t2_push_ready", 64'(s_ready), 64'd0);
    check("t2_pending", 64'(push_q.size()), 64'd2);
    pop_mode = 1;
    drive();
    run_until_done(100);

    // len=8 random repeat, random back-pressure and strobes
    do_start(8, $urandom_range(2, 4));
    pop_mode = 2;
    add_words(16, 1);
    drive();
    run_until_done(800);

    // Block length above depth saturates, zero behaves as one
    do_start(15, 2);
    add_words(8, 1);
    drive();
    run_until_done(300);
    do_start(0, 1);
    add_words(3, 1);
    drive();
    run_until_done(100);

    // start in the middle of a replay (rpt_cnt=1, rd_idx=2)
    do_start(4, 3);
    pop_mode = 1;
    add_words(4, 0);
    drive();
    n0 = n_pop;
    k = 0;
    while (n_pop - n0 < 6 && k < 100) begin
      cycle();
      k++;
    end
    check("t4_pops_before_start", 64'(n_pop - n0), 64'd6);
    do_start(2, 1);
    cycle();
    check("t4_valid_off", 64'(s_valid), 64'd0);
    check("t4_full_off", 64'(s_full), 64'd0);
    add_words(2, 1);
    drive();
    run_until_done(50);

    // rst_i and clear_i during fill; afterwards len=1, repeat=1
    for (int m = 0; m < 2; m++) begin
      do_start(4, 1);
      pop_mode = 0;
      add_words(6, 0);
      drive();
      repeat (5) cycle();
      do_reset(m == 1);
      pop_mode = 1;
      add_words(1, 1);
      drive();
      run_until_done(20);
    end

`ifdef NEUREKA_WBUF_PERF_EN
    // Five stalled cycles in replay; two starved cycles while filling
    do_start(2, 1);
    pop_mode = 0;
    add_words(2, 0);
    drive();
    n0 = n_acc;
    k = 0;
    while (n_acc - n0 < 2 && k < 20) begin
      cycle();
      k++;
    end
    repeat (5) cycle();
    pop_mode = 1;
    drive();
    run_until_done(50);
    check("perf_stall", 64'(perf_stall), 64'd5);
    check("perf_starve", 64'(perf_starve), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
